// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a uart_tx transmitter. It accepts bytes on a write strobe,
// then drains them one frame at a time through a send/ready handshake.
module uart_tx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clear_err,
    output logic [7:0]    tx_data,
    output logic          send,
    input  logic          tx_ready,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BUSY
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rdy_meta;
    logic          rdy_s;
    logic          push;
    logic          pop;
    logic          load;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // full is evaluated against the registered count, so a write to a full FIFO
    // is dropped even when the head is popped on the same edge.
    assign push = wr_en & ~full;
    assign pop  = (state == BUSY) & rdy_s;
    assign load = (state == IDLE) & ~empty & rdy_s;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, whatever order the simulator evaluates the blocks in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
        end else begin
            rdy_meta <= tx_ready;
            rdy_s    <= rdy_meta;
        end
    end

    // NOTE: the storage array has no reset; only pointers and count define which
    // entries are valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // The set condition wins over clear_err in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (clear_err) begin
            overflow <= 1'b0;
        end
    end

    // tx_data holds until the next load, so the transmitter sees a stable byte
    // when it latches one bit time after leaving READY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_data <= 8'h00;
        end else if (load) begin
            tx_data <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (load)   state_next = REQ;
            REQ:  if (!rdy_s) state_next = BUSY;
            BUSY: if (rdy_s)  state_next = IDLE;
            default:          state_next = IDLE;
        endcase
    end

    assign send = (state == REQ);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: an 8N1 transmitter model on its own clock
// and a queue-based occupancy/order model of the FIFO.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       clk_uart;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       clear_err;
    logic [7:0] tx_data;
    logic       send;
    logic       tx_ready;
    logic       busy;

    logic       m_en      = 1'b0;
    logic       m_ready   = 1'b1;
    logic       man_ready = 1'b1;
    int         m_phase   = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         checks    = 0;
    int         errors    = 0;
    int         accepted  = 0;
    int         pop_cnt   = 0;
    int         coincide  = 0;
    int         stab_err  = 0;
    logic       exp_ovf   = 1'b0;
    logic       prev_busy = 1'b0;
    logic       send_q    = 1'b0;
    logic [7:0] held      = 8'h00;

    assign tx_ready = m_en ? m_ready : man_ready;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .clear_err (clear_err),
        .tx_data   (tx_data),
        .send      (send),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        clk_uart = 1'b0;
        #2;
        forever begin
            clk_uart = 1'b1;
            #10;
            clk_uart = 1'b0;
            #10;
        end
    end

    // 8N1 transmitter, one bit per clk_uart cycle: leaves READY on send,
    // latches the byte after the start bit, returns READY after the stop bit.
    always @(posedge clk_uart) begin
        if (!m_en) begin
            m_ready <= 1'b1;
            m_phase <= 0;
        end else if (m_phase == 0) begin
            if (send) begin
                m_ready <= 1'b0;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            rx_q.push_back(tx_data);
            m_phase <= 2;
        end else if (m_phase < 10) begin
            m_phase <= m_phase + 1;
        end else begin
            m_ready <= 1'b1;
            m_phase <= 0;
        end
    end

    // A frame is retired on the edge where busy drops.
    always @(posedge clk) begin
        #1;
        if (prev_busy && !busy) pop_cnt++;
        prev_busy = busy;
    end

    always @(negedge clk) begin
        if (send && !send_q) held = tx_data;
        if (busy && tx_data !== held) stab_err++;
        send_q = send;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [7:0] b);
        int occ;
        int p0;
        bit acc;
        occ = accepted - pop_cnt;
        p0  = pop_cnt;
        wr_data = b;
        wr_en   = 1'b1;
        @(posedge clk);
        acc = (occ < DEPTH);
        if (acc) begin
            accepted++;
            exp_q.push_back(b);
        end
        if (!acc) exp_ovf = 1'b1;
        else if (clear_err) exp_ovf = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        if (acc && pop_cnt != p0) coincide++;
        occ = accepted - pop_cnt;
        checks++;
        if (count !== occ[4:0]) begin
            errors++;
            $display("FAIL write_count: got %0d expected %0d", count, occ);
        end
        checks++;
        if (full !== (occ == DEPTH)) begin
            errors++;
            $display("FAIL write_full: got %b expected %b", full, (occ == DEPTH));
        end
        checks++;
        if (empty !== (occ == 0)) begin
            errors++;
            $display("FAIL write_empty: got %b expected %b", empty, (occ == 0));
        end
        checks++;
        if (overflow !== exp_ovf) begin
            errors++;
            $display("FAIL write_overflow: got %b expected %b", overflow, exp_ovf);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (empty && !busy && m_phase == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clear_err = 1'b0;
        @(negedge clk);
        checks++;
        if ({count, empty, full, overflow, send, busy, tx_data} !== {5'd0, 1'b1, 4'b0000, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: got cnt=%0d e=%b f=%b o=%b s=%b b=%b d=%h expected cnt=0 e=1 f=0 o=0 s=0 b=0 d=00",
                     count, empty, full, overflow, send, busy, tx_data);
        end
        rst = 1'b1;
        wait_cycles(3);
        checks++;
        if (count !== 5'd0 || send !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got cnt=%0d s=%b e=%b expected cnt=0 s=0 e=1", count, send, empty);
        end
    endtask

    task automatic test_single_byte;
        int i;
        m_en = 1'b0; man_ready = 1'b1;
        wait_cycles(3);
        do_write(8'hA5);
        @(negedge clk);
        checks++;
        if (send !== 1'b1 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_latency: got send=%b data=%h expected send=1 data=a5", send, tx_data);
        end
        exp_q.delete();
        man_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (send !== 1'b1) begin
            errors++;
            $display("FAIL single_send_hold: got %b expected 1", send);
        end
        for (i = 0; i < 10 && send; i++) @(negedge clk);
        checks++;
        if (send !== 1'b0 || busy !== 1'b1 || count !== 5'd1) begin
            errors++;
            $display("FAIL single_send_fall: got send=%b busy=%b cnt=%0d expected send=0 busy=1 cnt=1", send, busy, count);
        end
        man_ready = 1'b1;
        for (i = 0; i < 10 && busy; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL single_done: got busy=%b cnt=%0d empty=%b expected busy=0 cnt=0 empty=1", busy, count, empty);
        end
    endtask

    task automatic test_burst;
        bit ok;
        m_en = 1'b1;
        rx_q.delete(); exp_q.delete();
        stab_err = 0;
        wait_cycles(3);
        for (int b = 0; b < DEPTH; b++) do_write(b[7:0]);
        checks++;
        if (full !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL burst_full: got full=%b cnt=%0d expected full=1 cnt=16", full, count);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL burst_drain_timeout: got busy=%b cnt=%0d expected drained", busy, count);
        end
        checks++;
        if (rx_q.size() != DEPTH) begin
            errors++;
            $display("FAIL burst_frames: got %0d expected %0d", rx_q.size(), DEPTH);
        end
        for (int i = 0; i < rx_q.size() && i < DEPTH; i++) begin
            checks++;
            if (rx_q[i] !== 8'(i)) begin
                errors++;
                $display("FAIL burst_byte%0d: got %h expected %h", i, rx_q[i], 8'(i));
            end
        end
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("FAIL burst_tx_data_stable: got %0d changes expected 0", stab_err);
        end
    endtask

    task automatic clear_pulse;
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        exp_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: got %b expected 0", overflow);
        end
    endtask

    task automatic test_overflow;
        bit ok;
        m_en = 1'b0; man_ready = 1'b0;
        rx_q.delete(); exp_q.delete();
        wait_cycles(3);
        for (int i = 0; i < DEPTH; i++) do_write(8'($urandom_range(0, 254)));
        do_write(8'hFF);
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL overflow_drop: got ovf=%b cnt=%0d expected ovf=1 cnt=16", overflow, count);
        end
        clear_pulse();
        clear_err = 1'b1;
        do_write(8'hFF);
        clear_err = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set_priority: got %b expected 1", overflow);
        end
        clear_pulse();
        m_en = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL overflow_drain: got ok=%b frames=%0d expected ok=1 frames=%0d", ok, rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL overflow_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_wrap_push_pop;
        bit   ok;
        int   written;
        int   i;
        logic mr_prev;
        m_en = 1'b1;
        rx_q.delete(); exp_q.delete();
        coincide = 0;
        written  = 0;
        for (int k = 0; k < 4; k++) begin
            do_write(8'($urandom));
            written++;
        end
        while (written < 20) begin
            mr_prev = m_ready;
            for (i = 0; i < 200; i++) begin
                @(negedge clk);
                if (m_ready && !mr_prev) break;
                mr_prev = m_ready;
            end
            checks++;
            if (i == 200) begin
                errors++;
                $display("FAIL wrap_ready_timeout: got no ready rise expected one within 200 cycles");
                break;
            end
            for (int k = 0; k < 3 && written < 20; k++) begin
                do_write(8'($urandom));
                written++;
            end
        end
        checks++;
        if (coincide == 0) begin
            errors++;
            $display("FAIL wrap_simultaneous: got %0d push/pop coincidences expected >0", coincide);
        end
        wait_drain(ok);
        checks++;
        if (!ok || rx_q.size() != 20) begin
            errors++;
            $display("FAIL wrap_drain: got ok=%b frames=%0d expected ok=1 frames=20", ok, rx_q.size());
        end
        for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (rx_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL wrap_byte%0d: got %h expected %h", k, rx_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        int i;
        m_en = 1'b1;
        rx_q.delete(); exp_q.delete();
        for (int k = 0; k < 6; k++) do_write(8'($urandom_range(0, 59)));
        for (i = 0; i < 200 && m_phase < 4; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || count !== 5'd6) begin
            errors++;
            $display("FAIL midreset_setup: got busy=%b cnt=%0d expected busy=1 cnt=6", busy, count);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({count, send, busy, empty, overflow, tx_data} !== {5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL midreset_async: got cnt=%0d s=%b b=%b e=%b o=%b d=%h expected cnt=0 s=0 b=0 e=1 o=0 d=00",
                     count, send, busy, empty, overflow, tx_data);
        end
        for (i = 0; i < 200 && !m_ready; i++) @(negedge clk);
        wait_cycles(2);
        accepted = 0; pop_cnt = 0; exp_ovf = 1'b0;
        rx_q.delete(); exp_q.delete();
        rst = 1'b1;
        wait_cycles(3);
        do_write(8'h3C);
        wait_drain(ok);
        checks++;
        if (!ok || rx_q.size() != 1) begin
            errors++;
            $display("FAIL midreset_frames: got ok=%b frames=%0d expected ok=1 frames=1", ok, rx_q.size());
        end else begin
            checks++;
            if (rx_q[0] !== 8'h3C) begin
                errors++;
                $display("FAIL midreset_next_byte: got %h expected 3c", rx_q[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_overflow();
        test_wrap_push_pop();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
